sram_access_scheduler: RTL
==========================

Name: sram_access_scheduler

Overview:
- Shares the single-port 256Kx16 audio SRAM between two requesters: the record path (ADC sample writes) and the playback path (DAC sample reads).
- Sequences every SRAM access as a fixed-length transaction with req/ack handshakes and round-robin arbitration.
- Sits between the recorder/player address generators and the SRAM pins in the top level.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- ACCESS_CYC, 2, cycles WE_n/OE_n are held active per access (legal range 1..15).

Ports:
- CLK50  in  1  system clock, 50 MHz.
- RST  in  1  asynchronous, active-high reset.
- wr_req  in  1  record path requests a write; held high until wr_ack.
- wr_addr  in  ADDR_W  write address, sampled at grant.
- wr_data  in  DATA_W  write data, sampled at grant.
- wr_ack  out  1  one-cycle pulse, write complete.
- rd_req  in  1  playback path requests a read; held high until rd_valid.
- rd_addr  in  ADDR_W  read address, sampled at grant.
- rd_data  out  DATA_W  read data, valid from the rd_valid pulse; holds until the next read completes.
- rd_valid  out  1  one-cycle pulse, rd_data updated.
- busy  out  1  high in any state other than IDLE.
- SRAM_ADDR  out  ADDR_W  SRAM address.
- SRAM_DATA  inout  DATA_W  SRAM data bus.
- SRAM_WE, SRAM_OE, SRAM_CE, SRAM_UB, SRAM_LB  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (async, RST=1): state IDLE; SRAM_WE=SRAM_OE=SRAM_CE=1; SRAM_UB=SRAM_LB=1; SRAM_DATA released (Z); SRAM_ADDR=0; rd_data=0; wr_ack=rd_valid=busy=0; last_grant=READ, so the first contested grant goes to the writer.
- Out of reset: SRAM_CE=SRAM_UB=SRAM_LB=0 permanently.
- FSM states: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, RD_DONE.
- IDLE, arbitration:
  - Only wr_req high -> WR_SETUP.
  - Only rd_req high -> RD_STROBE.
  - Both high -> grant the requester not in last_grant, then update last_grant.
  - At grant, latch the address (and wr_data for writes) into internal registers. The SRAM only sees these registers; requester inputs may change after grant.
- WR_SETUP (1 cycle): SRAM_ADDR and SRAM_DATA driven, WE_n=1.
- WR_STROBE (ACCESS_CYC cycles, counted by a 4-bit down-counter): WE_n=0; address and data stable.
- WR_HOLD (1 cycle): WE_n=1; data still driven; wr_ack=1; then IDLE.
- Write latency: wr_ack asserts ACCESS_CYC+2 cycles after the grant edge.
- RD_STROBE (ACCESS_CYC cycles): SRAM_ADDR driven, OE_n=0, bus Z. On the last cycle, register SRAM_DATA into rd_data.
- RD_DONE (1 cycle): OE_n=1; rd_valid=1; then IDLE.
- Read latency: rd_valid asserts ACCESS_CYC+1 cycles after the grant edge.
- WE_n and OE_n are never low in the same cycle. SRAM_DATA is driven only in WR_SETUP, WR_STROBE and WR_HOLD.
- Every transaction returns through IDLE, giving one idle cycle between accesses. With both requesters saturated they alternate strictly W,R,W,R.
- A requester that drops req before its ack/valid is not cancelled once granted; the transaction completes and still pulses ack/valid.
- A request raised in the same cycle the FSM leaves IDLE waits for the next IDLE.
- RST mid-transaction: immediate return to reset values. No ack/valid is emitted for the aborted access.

Decomposition:
- Shared package sram_pkg:
  - state enum;
  - ADDR_W/DATA_W defaults;
  - GRANT_WR/GRANT_RD encoding.
- One sub-module: sram_rr_arbiter, the combinational 2-way round-robin grant plus the last_grant register (CLK50/RST).

Test Plan:
- Write only: wr_req=1, wr_addr=18'h00010, wr_data=16'hBEEF, ACCESS_CYC=2 -> SRAM_WE low exactly 2 cycles with addr 10h and data BEEF stable; wr_ack pulses 4 cycles after grant; SRAM_OE stays 1.
- Read only: SRAM model holds A5A5 at 18'h00010; rd_req with rd_addr=10h -> OE low 2 cycles; rd_valid pulses 3 cycles after grant; rd_data=16'hA5A5 and holds after rd_valid falls.
- Contention: wr_req and rd_req rise together, held for 4 transactions -> grant order W,R,W,R; never WE_n=0 and OE_n=0 together; bus Z during reads.
- Input change after grant: change wr_addr/wr_data the cycle after grant -> SRAM sees the originally latched values.
- Reset mid-write: assert RST during WR_STROBE -> WE_n=1 and bus Z within the same cycle, no wr_ack. After release, the first contested grant goes to the writer.
- ACCESS_CYC=1 and 15 sweep: strobe widths are exactly 1 and 15 cycles; latencies are 3/2 and 17/16 cycles (write/read).

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the audio SRAM access scheduler.
package sram_pkg;

    localparam int unsigned ADDR_W_DEF = 18;
    localparam int unsigned DATA_W_DEF = 16;

    // Encoding of the round-robin history bit.
    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWrSetup,
        StWrStrobe,
        StWrHold,
        StRdStrobe,
        StRdDone
    } state_e;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin arbiter between the record (write) and playback (read) paths.
module sram_rr_arbiter
    import sram_pkg::*;
(
    input  logic CLK50,
    input  logic RST,
    input  logic wr_req_i,
    input  logic rd_req_i,
    input  logic arb_en_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);

    logic last_grant_q;

    // Grant decision: uncontested requests win outright, contested ones alternate.
    always_comb begin
        gnt_wr_o = 1'b0;
        gnt_rd_o = 1'b0;
        if (arb_en_i) begin
            if (wr_req_i && rd_req_i) begin
                if (last_grant_q == GRANT_RD) begin
                    gnt_wr_o = 1'b1;
                end else begin
                    gnt_rd_o = 1'b1;
                end
            end else if (wr_req_i) begin
                gnt_wr_o = 1'b1;
            end else if (rd_req_i) begin
                gnt_rd_o = 1'b1;
            end
        end
    end

    // History register; resetting to READ hands the first contested grant to the writer.
    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            last_grant_q <= GRANT_RD;
        end else if (gnt_wr_o) begin
            last_grant_q <= GRANT_WR;
        end else if (gnt_rd_o) begin
            last_grant_q <= GRANT_RD;
        end
    end

endmodule

// File: rtl/sram_access_scheduler.sv
// Sequences fixed-length SRAM write/read transactions for the record and playback paths.
module sram_access_scheduler
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ACCESS_CYC = 2  // strobe width, 1..15
) (
    input  logic              CLK50,
    input  logic              RST,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DATA,
    output logic              SRAM_WE,
    output logic              SRAM_OE,
    output logic              SRAM_CE,
    output logic              SRAM_UB,
    output logic              SRAM_LB
);

    // Strobe counter counts down to zero, so it is loaded with one less than the width.
    localparam logic [3:0] CntInit = 4'(ACCESS_CYC - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ce_q;
    logic              arb_en, gnt_wr, gnt_rd;
    logic              drive_bus;

    assign arb_en = (state_q == StIdle);

    sram_rr_arbiter u_arb (
        .CLK50    (CLK50),
        .RST      (RST),
        .wr_req_i (wr_req),
        .rd_req_i (rd_req),
        .arb_en_i (arb_en),
        .gnt_wr_o (gnt_wr),
        .gnt_rd_o (gnt_rd)
    );

    // Next-state logic; address and write data are captured at grant so requesters may move on.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (gnt_wr) begin
                    state_d = StWrSetup;
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                end else if (gnt_rd) begin
                    state_d = StRdStrobe;
                    addr_d  = rd_addr;
                    cnt_d   = CntInit;
                end
            end
            StWrSetup: begin
                state_d = StWrStrobe;
                cnt_d   = CntInit;
            end
            StWrStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StWrHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrHold: state_d = StIdle;
            StRdStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRdDone;
                    rdata_d = SRAM_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRdDone: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Chip enable and byte lanes sit inactive in reset and active forever after.
    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            ce_q <= 1'b1;
        end else begin
            ce_q <= 1'b0;
        end
    end

    // Strobes decode straight from state so a reset releases them without waiting for a clock.
    assign drive_bus = (state_q == StWrSetup) || (state_q == StWrStrobe) ||
                       (state_q == StWrHold);
    assign SRAM_WE   = (state_q != StWrStrobe);
    assign SRAM_OE   = (state_q != StRdStrobe);
    assign SRAM_CE   = ce_q;
    assign SRAM_UB   = ce_q;
    assign SRAM_LB   = ce_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_DATA = drive_bus ? wdata_q : {DATA_W{1'bz}};
    assign wr_ack    = (state_q == StWrHold);
    assign rd_valid  = (state_q == StRdDone);
    assign busy      = (state_q != StIdle);
    assign rd_data   = rdata_q;

endmodule
